fir_pwm_dac: RTL and testbench
==============================

FIR_PWM_DAC -- requirements
Module: fir_pwm_dac

Interface
REQ-001 Parameter N, default 32, width of the signed filter output word.
REQ-002 Parameter SHIFT, default 10, arithmetic right shift removing coefficient gain.
REQ-003 Parameter PWM_BITS, default 8, PWM resolution; PWM period is 2^PWM_BITS clk cycles.
REQ-004 clk  input  1  system clock (12 MHz nominal); the only clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 clk_d  input  1  sample-rate strobe from clk_divider, synchronous to clk.
REQ-007 ena  input  1  sample capture enable.
REQ-008 y_in  input  N  signed two's-complement sample from fir_n y_out.
REQ-009 pwm_out  output  1  registered PWM output.
REQ-010 duty  output  PWM_BITS  currently active duty value.
REQ-011 sat_pulse  output  1  one-cycle pulse when a captured sample clipped.
REQ-012 sat_count  output  16  saturating count of clipped samples.
REQ-013 overrun_count  output  8  saturating count of pending samples overwritten before use.

Function
REQ-014 Sample event SHALL be asserted in the clk cycle where clk_d=1, registered clk_d_q=0 and ena=1.
REQ-015 On an event, scaled = y_in >>> SHIFT, sign-extending and flooring toward minus infinity.
REQ-016 Scaled SHALL saturate to [-2^(PWM_BITS-1), 2^(PWM_BITS-1)-1], with sat_pulse=1 on the next cycle when clipping occurs.
REQ-017 Offset-binary duty value = saturated + 2^(PWM_BITS-1), stored in the pending register with pending_valid set one cycle after the event.
REQ-018 Counter cnt SHALL run 0..2^PWM_BITS-1 continuously and wrap to 0, regardless of ena.
REQ-019 On the cycle cnt wraps to 0, if pending_valid=1, duty SHALL load pending and pending_valid SHALL clear; otherwise duty SHALL be held.
REQ-020 If an event and a wrap occur in the same cycle, the new sample SHALL load directly into duty and pending_valid SHALL clear.
REQ-021 If an event occurs while pending_valid=1 and no wrap occurs, pending SHALL be overwritten and overrun_count SHALL increment.
REQ-022 pwm_out SHALL be registered (cnt < duty), one-cycle latency; duty 0 gives always low, and duty 2^PWM_BITS-1 gives low for exactly 1 cycle per period.
REQ-023 With ena=0, no capture occurs and the PWM SHALL continue at the held duty.
REQ-024 sat_count and overrun_count SHALL hold at all-ones and not wrap.

Reset
REQ-025 While rst=0: cnt=0, duty=2^(PWM_BITS-1) (midscale), pending=0, pending_valid=0, clk_d_q=0, pwm_out=0, sat_pulse=0, and both counts=0.
REQ-026 Reset asserted mid-period SHALL abort the period immediately, and the first period after release SHALL start at cnt=0.

Configuration
REQ-027 Macro FIR_PWM_STATS_EN defined: sat_count and overrun_count SHALL be implemented per REQ-012/013/021/024.
REQ-028 Macro FIR_PWM_STATS_EN undefined: both count outputs SHALL be constant 0 and their registers omitted; sat_pulse SHALL remain.

Structure
REQ-029 Package fir_pkg SHALL hold default N, SHIFT, PWM_BITS and the midscale constant, shared with fir_n benches.
REQ-030 Sub-module pwm_core SHALL contain cnt, the duty register and the compare; the saturation and pending logic SHALL stay in the top level.

Verification
REQ-031 Reset then idle -> duty=128; pwm_out high 128 of every 256 cycles.
REQ-032 y_in=193000 event -> scaled 188 clips to 127; sat_pulse once; sat_count=1; duty=255 after the next wrap.
REQ-033 y_in=-131072 -> duty=0, pwm_out constantly low; y_in=-1 -> duty=127 (floor behaviour).
REQ-034 Two events 40 cycles apart within one period (values 0 then 1024) -> overrun_count=1; duty=129 at the wrap.
REQ-035 Event coincident with the wrap cycle (y_in=2048) -> duty=130 in that period; pending_valid=0.
REQ-036 ena=0 during a clk_d rise with y_in=5120 -> duty unchanged; rst pulse mid-period -> all REQ-025 values, then normal restart.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults for the FIR output stage and its PWM DAC; also imported by fir_n benches.
package fir_pkg;
    localparam int unsigned N_DEFAULT        = 32;
    localparam int unsigned SHIFT_DEFAULT    = 10;
    localparam int unsigned PWM_BITS_DEFAULT = 8;
    localparam int unsigned MIDSCALE         = 1 << (PWM_BITS_DEFAULT - 1);
endpackage

// File: rtl/fir_pwm_dac_if.sv
// Sample-side bus from the FIR/clock-divider domain into the PWM DAC.
interface fir_pwm_dac_if
    import fir_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    logic                clk_d;
    logic                ena;
    logic signed [N-1:0] y_in;

    modport master (output clk_d, ena, y_in);
    modport slave  (input  clk_d, ena, y_in);
endinterface

// File: rtl/fir_pwm_dac_pwm_core.sv
// Free-running PWM counter, active duty register and registered compare.
module pwm_core #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PWM_BITS-1:0] load_val,
    output logic                wrap,
    output logic [PWM_BITS-1:0] duty,
    output logic                pwm_out
);
    localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] cnt;

    // wrap marks the last count of the period; the new duty takes effect as cnt returns to 0
    assign wrap = (cnt == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            duty    <= MID;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            pwm_out <= (cnt < duty);
            if (load)
                duty <= load_val;
        end
    end
endmodule

// File: rtl/fir_pwm_dac.sv
// FIR sample to PWM DAC: scale, saturate, offset-binary, double-buffered duty.
// Build option: define FIR_PWM_STATS_EN to implement sat_count/overrun_count.
module fir_pwm_dac
    import fir_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned SHIFT    = SHIFT_DEFAULT,
    parameter int unsigned PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    fir_pwm_dac_if.slave        smp,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                sat_pulse,
    output logic [15:0]         sat_count,
    output logic [7:0]          overrun_count
);
    localparam logic signed [N-1:0] SAT_MAX = N'((2 ** (PWM_BITS - 1)) - 1);
    localparam logic signed [N-1:0] SAT_MIN = N'(-(2 ** (PWM_BITS - 1)));

    logic                clk_d_q;
    logic                sample_evt;
    logic                wrap;
    logic                clip;
    logic                pending_valid;
    logic                duty_load;
    logic signed [N-1:0] scaled;
    logic [PWM_BITS-1:0] new_duty;
    logic [PWM_BITS-1:0] pending;
    logic [PWM_BITS-1:0] load_val;

    always_comb begin
        sample_evt = smp.clk_d & ~clk_d_q & smp.ena;
        scaled     = smp.y_in >>> SHIFT;
        clip       = 1'b0;
        // in-range values become offset-binary by flipping the sign bit
        if (scaled > SAT_MAX) begin
            new_duty = '1;
            clip     = 1'b1;
        end else if (scaled < SAT_MIN) begin
            new_duty = '0;
            clip     = 1'b1;
        end else begin
            new_duty = {~scaled[PWM_BITS-1], scaled[PWM_BITS-2:0]};
        end
        duty_load = wrap & (sample_evt | pending_valid);
        load_val  = sample_evt ? new_duty : pending;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_d_q       <= 1'b0;
            sat_pulse     <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            clk_d_q   <= smp.clk_d;
            sat_pulse <= sample_evt & clip;
            if (sample_evt && !wrap) begin
                pending       <= new_duty;
                pending_valid <= 1'b1;
            end else if (wrap) begin
                pending_valid <= 1'b0;
            end
        end
    end

`ifdef FIR_PWM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count     <= '0;
            overrun_count <= '0;
        end else begin
            if (sample_evt && clip && sat_count != '1)
                sat_count <= sat_count + 16'd1;
            if (sample_evt && !wrap && pending_valid && overrun_count != '1)
                overrun_count <= overrun_count + 8'd1;
        end
    end
`else
    assign sat_count     = '0;
    assign overrun_count = '0;
`endif

    pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (duty_load),
        .load_val (load_val),
        .wrap     (wrap),
        .duty     (duty),
        .pwm_out  (pwm_out)
    );
endmodule

// File: tb/tb_fir_pwm_dac.sv
// Self-checking bench for fir_pwm_dac with default parameters (N=32, SHIFT=10, PWM_BITS=8).
module tb_fir_pwm_dac;
    import fir_pkg::*;

`ifdef FIR_PWM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pwm_out;
    logic [7:0]  duty;
    logic        sat_pulse;
    logic [15:0] sat_count;
    logic [7:0]  overrun_count;

    always #5 clk = ~clk;

    fir_pwm_dac_if #(.N(32)) smp ();

    fir_pwm_dac #(.N(32), .SHIFT(10), .PWM_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .smp           (smp),
        .pwm_out       (pwm_out),
        .duty          (duty),
        .sat_pulse     (sat_pulse),
        .sat_count     (sat_count),
        .overrun_count (overrun_count)
    );

    // reference model of counter phase and statistics
    logic [7:0] m_cnt;
    logic       m_q;
    logic       m_pv;
    logic [8:0] m_c;
    int         m_sat;
    int         m_ovr;

    function automatic logic [8:0] conv(input logic signed [31:0] y);
        logic signed [31:0] s;
        s = y >>> 10;
        if (s > 127)  return {1'b1, 8'hFF};
        if (s < -128) return {1'b1, 8'h00};
        return {1'b0, 8'(s + 128)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= '0; m_q <= 1'b0; m_pv <= 1'b0; m_sat <= 0; m_ovr <= 0;
        end else begin
            m_c = conv(smp.y_in);
            if (smp.clk_d && !m_q && smp.ena) begin
                if (m_c[8] && m_sat < 65535) m_sat <= m_sat + 1;
                if (m_cnt == 8'hFF) m_pv <= 1'b0;
                else begin
                    if (m_pv && m_ovr < 255) m_ovr <= m_ovr + 1;
                    m_pv <= 1'b1;
                end
            end else if (m_cnt == 8'hFF) begin
                m_pv <= 1'b0;
            end
            m_q   <= smp.clk_d;
            m_cnt <= m_cnt + 8'd1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_cnt(input int v);
        int k;
        k = 0;
        while (m_cnt != 8'(v) && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (k >= 600) chk("wait_cnt_timeout", 32'(m_cnt), 32'(v));
    endtask

    task automatic fire(input logic signed [31:0] y, input logic en);
        smp.clk_d = 1'b1; smp.ena = en; smp.y_in = y;
        @(negedge clk);
        smp.clk_d = 1'b0; smp.ena = 1'b0;
    endtask

    task automatic measure(input int exp, input string nm);
        int hi;
        hi = 0;
        wait_cnt(1);
        repeat (256) begin
            if (pwm_out) hi++;
            @(negedge clk);
        end
        chk(nm, 32'(hi), 32'(exp));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_duty"}, 32'(duty), 32'd128);
        chk({tag, "_pwm"}, 32'(pwm_out), 32'd0);
        chk({tag, "_sat_pulse"}, 32'(sat_pulse), 32'd0);
        chk({tag, "_sat_count"}, 32'(sat_count), 32'd0);
        chk({tag, "_ovr_count"}, 32'(overrun_count), 32'd0);
    endtask

    typedef struct {
        logic signed [31:0] y;
        logic [7:0]         duty;
        logic               clip;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int clips;
        vecs[0] = '{0,       8'd128, 1'b0};
        vecs[1] = '{193000,  8'd255, 1'b1};
        vecs[2] = '{-131072, 8'd0,   1'b0};
        vecs[3] = '{-1,      8'd127, 1'b0};
        vecs[4] = '{1024,    8'd129, 1'b0};
        vecs[5] = '{-200000, 8'd0,   1'b1};
        vecs[6] = '{130047,  8'd254, 1'b0};
        vecs[7] = '{131072,  8'd255, 1'b1};
        vecs[8] = '{-132096, 8'd0,   1'b1};
        clips = 0;

        smp.clk_d = 1'b0; smp.ena = 1'b0; smp.y_in = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b1;
        measure(128, "idle_high_cycles");
        chk("idle_duty", 32'(duty), 32'd128);

        for (int i = 0; i < 9; i++) begin
            wait_cnt(10);
            fire(vecs[i].y, 1'b1);
            exp_q.push_back(vecs[i].duty);
            chk($sformatf("v%0d_sat_pulse", i), 32'(sat_pulse), 32'(vecs[i].clip));
            @(negedge clk);
            chk($sformatf("v%0d_sat_pulse_width", i), 32'(sat_pulse), 32'd0);
            if (vecs[i].clip) clips++;
            wait_cnt(0);
            chk($sformatf("v%0d_duty", i), 32'(duty), 32'(exp_q.pop_front()));
            measure(int'(vecs[i].duty), $sformatf("v%0d_high_cycles", i));
        end
        chk("sat_count", 32'(sat_count), STATS ? 32'(clips) : 32'd0);
        chk("sat_count_model", 32'(sat_count), STATS ? 32'(m_sat) : 32'd0);

        // two events in one period: the second overwrites pending
        wait_cnt(20); fire(0, 1'b1);
        wait_cnt(60); fire(1024, 1'b1);
        exp_q.push_back(8'd129);
        wait_cnt(0);
        chk("overrun_duty", 32'(duty), 32'(exp_q.pop_front()));
        chk("overrun_count", 32'(overrun_count), STATS ? 32'd1 : 32'd0);

        // event on the wrap cycle loads duty directly
        wait_cnt(255); fire(2048, 1'b1);
        chk("coincident_duty", 32'(duty), 32'd130);
        chk("coincident_pending_valid", 32'(dut.pending_valid), 32'd0);
        measure(130, "coincident_high_cycles");
        wait_cnt(0);
        chk("coincident_no_stale", 32'(duty), 32'd130);

        // ena low: clk_d rise ignored
        wait_cnt(30); fire(5120, 1'b0);
        wait_cnt(0);
        chk("ena_low_duty", 32'(duty), 32'd130);
        chk("ena_low_pending_valid", 32'(dut.pending_valid), 32'd0);

        // reset mid-period
        wait_cnt(100);
        rst = 1'b0;
        #1;
        chk_reset_state("midreset");
        chk("midreset_cnt", 32'(dut.u_core.cnt), 32'd0);
        chk("midreset_pending", 32'(dut.pending), 32'd0);
        chk("midreset_pending_valid", 32'(dut.pending_valid), 32'd0);
        chk("midreset_clk_d_q", 32'(dut.clk_d_q), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        measure(128, "restart_high_cycles");

        // back-to-back overruns drive overrun_count into saturation
        for (int p = 0; p < 3; p++) begin
            for (int k = 2; k <= 250; k += 2) begin
                wait_cnt(k);
                fire(32'sd4096, 1'b1);
            end
            wait_cnt(0);
            if (p == 1) chk("overrun_two_periods", 32'(overrun_count), STATS ? 32'd248 : 32'd0);
        end
        chk("overrun_saturated", 32'(overrun_count), STATS ? 32'd255 : 32'd0);
        chk("overrun_model", 32'(overrun_count), STATS ? 32'(m_ovr) : 32'd0);
        chk("final_duty", 32'(duty), 32'd132);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
